// File: rtl/accelerator_transformer_scaled_dot_product.sv
// Streaming attention-score engine: S[i][j] = sat((Q[i].K[j]) >>> SCALE), emitted row-major,
// with an optional causal mask that forces future columns to the most negative word.
module accelerator_transformer_scaled_dot_product #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 4,
   parameter int INDEX_SIZE   = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   input  logic [INDEX_SIZE-1:0]   SIZE_I_IN,
   input  logic [INDEX_SIZE-1:0]   SIZE_J_IN,
   input  logic [INDEX_SIZE-1:0]   SIZE_K_IN,
   input  logic [CONTROL_SIZE-1:0] SCALE_IN,
   input  logic                    MASK_IN,
   input  logic                    DATA_IN_ENABLE,
   input  logic [DATA_SIZE-1:0]    DATA_A_IN,
   input  logic [DATA_SIZE-1:0]    DATA_B_IN,
   output logic                    DATA_IN_READY,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic                    DATA_OUT_ENABLE,
   output logic                    DATA_I_ENABLE,
   output logic                    OVERFLOW_OUT,
   output logic                    READY
);

   localparam int ACC_W  = 2 * DATA_SIZE + INDEX_SIZE;
   localparam int HEAD_W = ACC_W - DATA_SIZE + 1;
   localparam logic [DATA_SIZE-1:0]  MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};
   localparam logic [DATA_SIZE-1:0]  MOST_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};
   localparam logic [INDEX_SIZE-1:0] ONE      = INDEX_SIZE'(1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUMULATE,
      EMIT,
      DONE
   } state_t;

   state_t                    state_q;
   logic [INDEX_SIZE-1:0]     sizeI_q;
   logic [INDEX_SIZE-1:0]     sizeJ_q;
   logic [INDEX_SIZE-1:0]     sizeK_q;
   logic [CONTROL_SIZE-1:0]   scale_q;
   logic                      mask_q;
   logic [INDEX_SIZE-1:0]     iCount_q;
   logic [INDEX_SIZE-1:0]     jCount_q;
   logic [INDEX_SIZE-1:0]     kCount_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic [DATA_SIZE-1:0]      dataOut_q;
   logic                      outEnable_q;
   logic                      rowEnd_q;
   logic                      overflow_q;
   logic                      ready_q;

   logic signed [2*DATA_SIZE-1:0] aExt_d;
   logic signed [2*DATA_SIZE-1:0] bExt_d;
   logic signed [2*DATA_SIZE-1:0] product_d;
   logic signed [ACC_W-1:0]       sum_d;
   logic signed [ACC_W-1:0]       shifted_d;
   logic [HEAD_W-1:0]             head_d;
   logic                          masked_d;
   logic                          saturate_d;
   logic [DATA_SIZE-1:0]          score_d;
   logic                          lastK_d;
   logic                          lastJ_d;
   logic                          lastI_d;
   logic                          anyZero_d;

   // Score datapath: the sum includes the pair being accepted, so the score for the
   // last k is ready to register on the same edge that consumes that pair.
   always_comb begin
      aExt_d     = {{DATA_SIZE{DATA_A_IN[DATA_SIZE-1]}}, DATA_A_IN};
      bExt_d     = {{DATA_SIZE{DATA_B_IN[DATA_SIZE-1]}}, DATA_B_IN};
      product_d  = aExt_d * bExt_d;
      sum_d      = acc_q + {{INDEX_SIZE{product_d[2*DATA_SIZE-1]}}, product_d};
      shifted_d  = sum_d >>> scale_q;
      head_d     = shifted_d[ACC_W-1:DATA_SIZE-1];
      masked_d   = mask_q && (jCount_q > iCount_q);
      saturate_d = !((&head_d) || !(|head_d));
      if (masked_d) begin
         score_d = MOST_NEG;
      end else if (saturate_d) begin
         score_d = shifted_d[ACC_W-1] ? MOST_NEG : MOST_POS;
      end else begin
         score_d = shifted_d[DATA_SIZE-1:0];
      end
      lastK_d   = (kCount_q == sizeK_q - ONE);
      lastJ_d   = (jCount_q == sizeJ_q - ONE);
      lastI_d   = (iCount_q == sizeI_q - ONE);
      anyZero_d = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (SIZE_K_IN == '0);
   end

   // Control FSM with registered strobes; run parameters are frozen at START.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         sizeI_q     <= '0;
         sizeJ_q     <= '0;
         sizeK_q     <= '0;
         scale_q     <= '0;
         mask_q      <= 1'b0;
         iCount_q    <= '0;
         jCount_q    <= '0;
         kCount_q    <= '0;
         acc_q       <= '0;
         dataOut_q   <= '0;
         outEnable_q <= 1'b0;
         rowEnd_q    <= 1'b0;
         overflow_q  <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         outEnable_q <= 1'b0;
         rowEnd_q    <= 1'b0;
         ready_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (START) begin
                  sizeI_q    <= SIZE_I_IN;
                  sizeJ_q    <= SIZE_J_IN;
                  sizeK_q    <= SIZE_K_IN;
                  scale_q    <= SCALE_IN;
                  mask_q     <= MASK_IN;
                  iCount_q   <= '0;
                  jCount_q   <= '0;
                  kCount_q   <= '0;
                  acc_q      <= '0;
                  overflow_q <= 1'b0;
                  if (anyZero_d) begin
                     state_q <= DONE;
                     ready_q <= 1'b1;
                  end else begin
                     state_q <= ACCUMULATE;
                  end
               end
            end
            ACCUMULATE: begin
               if (DATA_IN_ENABLE) begin
                  if (lastK_d) begin
                     dataOut_q   <= score_d;
                     outEnable_q <= 1'b1;
                     rowEnd_q    <= lastJ_d;
                     if (!masked_d && saturate_d) begin
                        overflow_q <= 1'b1;
                     end
                     acc_q    <= '0;
                     kCount_q <= '0;
                     state_q  <= EMIT;
                  end else begin
                     acc_q    <= sum_d;
                     kCount_q <= kCount_q + ONE;
                  end
               end
            end
            EMIT: begin
               if (!lastJ_d) begin
                  jCount_q <= jCount_q + ONE;
                  state_q  <= ACCUMULATE;
               end else if (!lastI_d) begin
                  jCount_q <= '0;
                  iCount_q <= iCount_q + ONE;
                  state_q  <= ACCUMULATE;
               end else begin
                  state_q <= DONE;
                  ready_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign DATA_IN_READY   = (state_q == ACCUMULATE);
   assign DATA_OUT        = dataOut_q;
   assign DATA_OUT_ENABLE = outEnable_q;
   assign DATA_I_ENABLE   = rowEnd_q;
   assign OVERFLOW_OUT    = overflow_q;
   assign READY           = ready_q;

endmodule

// File: tb/tb_accelerator_transformer_scaled_dot_product.sv
// Scoreboard bench for the scaled dot-product engine: a behavioural model queues expected
// scores as each run is set up, and a monitor pops and compares them on every output strobe.
module tb_accelerator_transformer_scaled_dot_product;

   localparam int DW = 16;
   localparam int CW = 4;
   localparam int IW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          rowEnd;
   } exp_t;

   logic          clock = 1'b0;
   logic          rstN;
   logic          start;
   logic [IW-1:0] sizeI;
   logic [IW-1:0] sizeJ;
   logic [IW-1:0] sizeK;
   logic [CW-1:0] scale;
   logic          mask;
   logic          inEnable;
   logic [DW-1:0] dataA;
   logic [DW-1:0] dataB;
   logic          inReady;
   logic [DW-1:0] dataOut;
   logic          outEnable;
   logic          rowEnable;
   logic          overflow;
   logic          ready;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   int strobeCount = 0;
   int readyCount = 0;
   int readyCycle = -100;
   int lastStrobeCycle = -100;
   int lastAcceptCycle = -100;

   exp_t                 sbQ[$];
   logic signed [DW-1:0] pa[$];
   logic signed [DW-1:0] pb[$];

   logic jobExpOvf;
   int   jobStrobes;
   int   jobAccepted;
   int   jobStartCycle;
   bit   jobTimedOut;

   accelerator_transformer_scaled_dot_product #(
      .DATA_SIZE(DW),
      .CONTROL_SIZE(CW),
      .INDEX_SIZE(IW)
   ) dut (
      .CLK(clock),
      .RST(rstN),
      .START(start),
      .SIZE_I_IN(sizeI),
      .SIZE_J_IN(sizeJ),
      .SIZE_K_IN(sizeK),
      .SCALE_IN(scale),
      .MASK_IN(mask),
      .DATA_IN_ENABLE(inEnable),
      .DATA_A_IN(dataA),
      .DATA_B_IN(dataB),
      .DATA_IN_READY(inReady),
      .DATA_OUT(dataOut),
      .DATA_OUT_ENABLE(outEnable),
      .DATA_I_ENABLE(rowEnable),
      .OVERFLOW_OUT(overflow),
      .READY(ready)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   // Monitor: pops one expected score per strobe and tracks READY pulses.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (rstN) begin
         if (outEnable) begin
            strobeCount++;
            lastStrobeCycle = cycle;
            vectors++;
            if (sbQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL unexpected_strobe: got DATA_OUT=%h with no score pending", dataOut);
            end else begin
               e = sbQ.pop_front();
               if ({dataOut, rowEnable} !== {e.data, e.rowEnd}) begin
                  miscompares++;
                  $display("[TB] FAIL score: got data=%h row_end=%b, expected data=%h row_end=%b",
                           dataOut, rowEnable, e.data, e.rowEnd);
               end
               vectors++;
               if (cycle !== lastAcceptCycle + 1) begin
                  miscompares++;
                  $display("[TB] FAIL strobe_latency: strobe in cycle %0d, expected cycle %0d",
                           cycle, lastAcceptCycle + 1);
               end
            end
         end
         if (ready) begin
            readyCount++;
            readyCycle = cycle;
         end
      end
   end

   // Builds the expected scores from pa/pb, starts a run, feeds the pairs and waits for READY.
   task automatic runJob(input int ni, input int nj, input int nk, input int scl,
                         input bit msk, input bit gaps, input bit poke);
      int   idx;
      int   total;
      int   strobesBefore;
      int   readyBefore;
      int   pc;
      bit   en;
      logic rdy;
      longint acc;
      longint sh;
      exp_t e;
      jobExpOvf = 1'b0;
      idx = 0;
      if (ni > 0 && nj > 0 && nk > 0) begin
         for (int i = 0; i < ni; i++) begin
            for (int j = 0; j < nj; j++) begin
               acc = 0;
               for (int k = 0; k < nk; k++) begin
                  acc += longint'(pa[idx]) * longint'(pb[idx]);
                  idx++;
               end
               if (msk && j > i) begin
                  e.data = 16'h8000;
               end else begin
                  sh = acc >>> scl;
                  if (sh > 32767) begin
                     e.data = 16'h7FFF;
                     jobExpOvf = 1'b1;
                  end else if (sh < -32768) begin
                     e.data = 16'h8000;
                     jobExpOvf = 1'b1;
                  end else begin
                     e.data = sh[15:0];
                  end
               end
               e.rowEnd = (j == nj - 1);
               sbQ.push_back(e);
            end
         end
      end
      total = (ni > 0 && nj > 0 && nk > 0) ? ni * nj * nk : 0;
      strobesBefore = strobeCount;
      readyBefore = readyCount;

      @(negedge clock);
      inEnable = 1'b0;
      sizeI = IW'(ni);
      sizeJ = IW'(nj);
      sizeK = IW'(nk);
      scale = CW'(scl);
      mask = msk;
      start = 1'b1;
      jobStartCycle = cycle;
      @(posedge clock);
      #1;
      start = 1'b0;
      sizeI = IW'($urandom);
      sizeJ = IW'($urandom);
      sizeK = IW'($urandom);
      scale = CW'($urandom);
      mask = 1'($urandom);

      idx = 0;
      for (int c = 0; c < 40 * total + 40 && idx < total; c++) begin
         @(negedge clock);
         en = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         inEnable = en;
         dataA = pa[idx];
         dataB = pb[idx];
         start = (poke && idx == total / 2);
         rdy = inReady;
         pc = cycle;
         @(posedge clock);
         #1;
         start = 1'b0;
         if (en && rdy) begin
            idx++;
            lastAcceptCycle = pc;
         end
      end
      jobAccepted = idx;

      if (!gaps) begin
         inEnable = 1'b1;
         dataA = 16'h1234;
         dataB = 16'h4321;
      end else begin
         inEnable = 1'b0;
      end
      for (int c = 0; c < 40 && readyCount == readyBefore; c++) @(posedge clock);
      jobTimedOut = (readyCount == readyBefore);
      jobStrobes = strobeCount - strobesBefore;
      @(negedge clock);
      inEnable = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      vectors++;
      if ({dataOut, outEnable, rowEnable, overflow, ready, inReady} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got out=%h en=%b row=%b ovf=%b rdy=%b inrdy=%b, expected all 0",
                  dataOut, outEnable, rowEnable, overflow, ready, inReady);
      end
      rstN = 1'b1;
      repeat (2) @(negedge clock);
      vectors++;
      if ({dataOut, outEnable, overflow, ready, inReady} !== '0) begin
         miscompares++;
         $display("[TB] FAIL idle_outputs: got out=%h en=%b ovf=%b rdy=%b inrdy=%b, expected all 0",
                  dataOut, outEnable, overflow, ready, inReady);
      end
   endtask

   task automatic test_basic();
      pa = '{1, 2, 3};
      pb = '{4, 5, 6};
      runJob(1, 1, 3, 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (jobStrobes !== 1 || jobTimedOut) begin
         miscompares++;
         $display("[TB] FAIL basic_strobes: got %0d strobes timeout=%b, expected 1 strobe and READY",
                  jobStrobes, jobTimedOut);
      end
      vectors++;
      if (readyCycle !== lastStrobeCycle + 1) begin
         miscompares++;
         $display("[TB] FAIL basic_ready_latency: READY in cycle %0d, expected %0d",
                  readyCycle, lastStrobeCycle + 1);
      end
      vectors++;
      if (jobAccepted !== 3) begin
         miscompares++;
         $display("[TB] FAIL basic_pairs: consumed %0d pairs, expected 3", jobAccepted);
      end
      runJob(1, 1, 3, 2, 1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clock);
      vectors++;
      if (dataOut !== 16'h0008 || overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL scaled_hold: got DATA_OUT=%h ovf=%b, expected 0008 ovf=0", dataOut, overflow);
      end
   endtask

   task automatic test_negative_shift();
      pa = '{-7};
      pb = '{1};
      runJob(1, 1, 1, 1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (dataOut !== 16'hFFFC || overflow !== 1'b0 || jobTimedOut) begin
         miscompares++;
         $display("[TB] FAIL negative_floor: got DATA_OUT=%h ovf=%b, expected FFFC ovf=0", dataOut, overflow);
      end
   endtask

   task automatic test_causal_mask();
      pa = '{1, 1, 1, 1};
      pb = '{1, 1, 1, 1};
      runJob(2, 2, 1, 0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (jobStrobes !== 4 || overflow !== 1'b0 || jobTimedOut) begin
         miscompares++;
         $display("[TB] FAIL mask_run: got %0d strobes ovf=%b, expected 4 strobes ovf=0", jobStrobes, overflow);
      end
   endtask

   task automatic test_saturation();
      pa = '{16'sh7FFF, 16'sh7FFF};
      pb = '{16'sh7FFF, 16'sh7FFF};
      runJob(1, 1, 2, 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL sat_flag: got OVERFLOW_OUT=%b, expected 1", overflow);
      end
      repeat (4) @(negedge clock);
      vectors++;
      if (overflow !== 1'b1 || dataOut !== 16'h7FFF) begin
         miscompares++;
         $display("[TB] FAIL sat_sticky: got ovf=%b DATA_OUT=%h, expected ovf=1 DATA_OUT=7FFF", overflow, dataOut);
      end
      pa = '{2};
      pb = '{3};
      runJob(1, 1, 1, 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sat_clear: got OVERFLOW_OUT=%b after new run, expected 0", overflow);
      end
   endtask

   task automatic test_zero_size();
      pa.delete();
      pb.delete();
      runJob(1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (jobStrobes !== 0 || jobTimedOut || readyCycle !== jobStartCycle + 1) begin
         miscompares++;
         $display("[TB] FAIL zero_k: got strobes=%0d timeout=%b READY cycle %0d, expected 0 strobes READY cycle %0d",
                  jobStrobes, jobTimedOut, readyCycle, jobStartCycle + 1);
      end
      runJob(0, 2, 2, 0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (jobStrobes !== 0 || jobTimedOut) begin
         miscompares++;
         $display("[TB] FAIL zero_i: got strobes=%0d timeout=%b, expected 0 strobes and READY",
                  jobStrobes, jobTimedOut);
      end
   endtask

   task automatic test_reset_midrun();
      int strobesBefore;
      int readyBefore;
      pa = '{16'sh7FFF};
      pb = '{16'sh8000};
      runJob(1, 1, 1, 0, 1'b0, 1'b0, 1'b0);
      strobesBefore = strobeCount;
      readyBefore = readyCount;
      @(negedge clock);
      sizeI = 8'd1;
      sizeJ = 8'd1;
      sizeK = 8'd4;
      scale = '0;
      mask = 1'b0;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (2) begin
         @(negedge clock);
         inEnable = 1'b1;
         dataA = 16'd5;
         dataB = 16'd5;
      end
      @(negedge clock);
      rstN = 1'b0;
      inEnable = 1'b0;
      #1;
      vectors++;
      if ({dataOut, outEnable, rowEnable, overflow, ready, inReady} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midrun_reset_outputs: got out=%h en=%b row=%b ovf=%b rdy=%b inrdy=%b, expected all 0",
                  dataOut, outEnable, rowEnable, overflow, ready, inReady);
      end
      repeat (2) @(negedge clock);
      rstN = 1'b1;
      repeat (10) @(negedge clock);
      vectors++;
      if (readyCount !== readyBefore || strobeCount !== strobesBefore) begin
         miscompares++;
         $display("[TB] FAIL midrun_abort: got %0d READY and %0d strobes after abort, expected 0 and 0",
                  readyCount - readyBefore, strobeCount - strobesBefore);
      end
      pa = '{1, 2, 3};
      pb = '{4, 5, 6};
      runJob(1, 1, 3, 0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (jobStrobes !== 1 || jobTimedOut || dataOut !== 16'd32) begin
         miscompares++;
         $display("[TB] FAIL post_reset_run: got strobes=%0d timeout=%b DATA_OUT=%h, expected 1 strobe 0020",
                  jobStrobes, jobTimedOut, dataOut);
      end
   endtask

   task automatic test_back_to_back();
      int ni;
      int nj;
      int nk;
      int v;
      for (int t = 0; t < 8; t++) begin
         ni = $urandom_range(1, 3);
         nj = $urandom_range(1, 3);
         nk = $urandom_range(1, 4);
         pa.delete();
         pb.delete();
         for (int n = 0; n < ni * nj * nk; n++) begin
            if (t >= 5) begin
               pa.push_back(($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000);
               pb.push_back(($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000);
            end else begin
               v = $urandom_range(0, 4000) - 2000;
               pa.push_back(16'(v));
               v = $urandom_range(0, 4000) - 2000;
               pb.push_back(16'(v));
            end
         end
         runJob(ni, nj, nk, $urandom_range(0, 15), 1'($urandom), 1'(t % 2), 1'b1);
         vectors++;
         if (jobStrobes !== ni * nj || jobAccepted !== ni * nj * nk || jobTimedOut) begin
            miscompares++;
            $display("[TB] FAIL b2b_counts[%0d]: got strobes=%0d pairs=%0d timeout=%b, expected %0d and %0d",
                     t, jobStrobes, jobAccepted, jobTimedOut, ni * nj, ni * nj * nk);
         end
         vectors++;
         if (overflow !== jobExpOvf) begin
            miscompares++;
            $display("[TB] FAIL b2b_overflow[%0d]: got %b, expected %b", t, overflow, jobExpOvf);
         end
      end
   endtask

   initial begin
      rstN = 1'b0;
      start = 1'b0;
      sizeI = '0;
      sizeJ = '0;
      sizeK = '0;
      scale = '0;
      mask = 1'b0;
      inEnable = 1'b0;
      dataA = '0;
      dataB = '0;
      repeat (2) @(negedge clock);
      test_reset();
      test_basic();
      test_negative_shift();
      test_causal_mask();
      test_saturation();
      test_zero_size();
      test_reset_midrun();
      test_back_to_back();
      repeat (3) @(negedge clock);
      vectors++;
      if (sbQ.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL leftover_scores: %0d expected scores never produced, expected 0", sbQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
